// File: rtl/matrix_mult_pkg.sv
// -----------------------------------------------------------------------------
// matrix_mult_pkg
//   Shared definitions for the matrix-multiply accelerator driver: the
//   controller state encoding, the host RAM bank selects and a small sizing
//   helper.
// -----------------------------------------------------------------------------
package matrix_mult_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    KICK,
    WAIT_BUSY,
    RUN,
    RD_ADDR,
    RD_DATA,
    FINISH
  } state_e;

  // Host RAM bank selects.
  localparam logic [1:0] SEL_X = 2'b00;
  localparam logic [1:0] SEL_Y = 2'b01;
  localparam logic [1:0] SEL_Z = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/matrix_mult_driver.sv
// -----------------------------------------------------------------------------
// matrix_mult_driver
//   Streams operand matrices X then Y (row-major) into the accelerator host
//   RAM, kicks the accelerator, waits for it to finish and streams the Z
//   result back out (row-major) with a valid/ready handshake.
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      operand stream, X then Y
//   out_valid/out_ready/out_data   Z result stream, out_last on final beat
//   ram_addr/ram_wen/ram_sel       accelerator host RAM port; reads have one
//   ram_data_in/ram_data_out         cycle of latency
//   start/busy                     accelerator control
//   done                           one-cycle pulse after the last Z beat
//   error                          sticky timeout flag
//
// Build option
//   MATRIX_MULT_DRIVER_TIMEOUT_EN  when defined, WAIT_BUSY gives up after 16
//                                  cycles and RUN after 4096, setting error
//                                  and returning to IDLE. Otherwise both
//                                  states wait forever and error is 0.
// -----------------------------------------------------------------------------
module matrix_mult_driver
  import matrix_mult_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int X_ROWS        = 5,
  parameter int Y_COLS        = 5,
  parameter int X_COLS_Y_ROWS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wen,
  output logic [1:0]            ram_sel,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  start,
  input  logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int X_N   = X_ROWS * X_COLS_Y_ROWS;
  localparam int Y_N   = X_COLS_Y_ROWS * Y_COLS;
  localparam int Z_N   = X_ROWS * Y_COLS;
  localparam int MAX_N = max3(X_N, Y_N, Z_N);
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_N - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y_N - 1);
  localparam logic [CNT_W-1:0] Z_LAST = CNT_W'(Z_N - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

`ifdef MATRIX_MULT_DRIVER_TIMEOUT_EN
  localparam int WAIT_LIMIT = 16;
  localparam int RUN_LIMIT  = 4096;
  localparam int TMR_W      = $clog2(RUN_LIMIT);
  localparam logic [TMR_W-1:0] WAIT_TMR_LAST = TMR_W'(WAIT_LIMIT - 1);
  localparam logic [TMR_W-1:0] RUN_TMR_LAST  = TMR_W'(RUN_LIMIT - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             error_q, error_d;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef MATRIX_MULT_DRIVER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q   <= '0;
      error_q <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      error_q <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  // The counter doubles as the RAM address in every phase.
  assign ram_addr  = ADDR_WIDTH'(cnt_q);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    in_ready    = 1'b0;
    ram_wen     = 1'b0;
    ram_sel     = SEL_Z;
    ram_data_in = '0;
    start       = 1'b0;
    done        = 1'b0;
`ifdef MATRIX_MULT_DRIVER_TIMEOUT_EN
    tmr_d       = tmr_q;
    error_d     = error_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = LOAD_X;
          cnt_d   = '0;
`ifdef MATRIX_MULT_DRIVER_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end

      LOAD_X: begin
        ram_sel  = SEL_X;
        in_ready = 1'b1;
        if (in_valid) begin
          ram_wen     = 1'b1;
          ram_data_in = in_data;
          if (cnt_q == X_LAST) begin
            cnt_d   = '0;
            state_d = LOAD_Y;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      LOAD_Y: begin
        ram_sel  = SEL_Y;
        in_ready = 1'b1;
        if (in_valid) begin
          ram_wen     = 1'b1;
          ram_data_in = in_data;
          if (cnt_q == Y_LAST) begin
            cnt_d   = '0;
            state_d = KICK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      KICK: begin
        start   = 1'b1;
        state_d = WAIT_BUSY;
`ifdef MATRIX_MULT_DRIVER_TIMEOUT_EN
        tmr_d   = '0;
`endif
      end

      WAIT_BUSY: begin
        if (busy) begin
          state_d = RUN;
`ifdef MATRIX_MULT_DRIVER_TIMEOUT_EN
          tmr_d   = '0;
        end else if (tmr_q == WAIT_TMR_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
`endif
        end
      end

      RUN: begin
        if (!busy) begin
          state_d = RD_ADDR;
          cnt_d   = '0;
`ifdef MATRIX_MULT_DRIVER_TIMEOUT_EN
        end else if (tmr_q == RUN_TMR_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
`endif
        end
      end

      // Address is presented here; the RAM returns it one cycle later.
      RD_ADDR: state_d = RD_DATA;

      // First cycle captures the read data; afterwards the beat is held
      // until the consumer takes it.
      RD_DATA: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = ram_data_out;
          out_last_d  = (cnt_q == Z_LAST);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = FINISH;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = RD_ADDR;
          end
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
